// File: rtl/mips_iter_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU. One quotient bit per clock;
// results go to HI (remainder) and LO (quotient).
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   start, is_signed    request a division (DIV when is_signed=1, DIVU otherwise)
//   dividend, divisor   operands, sampled on the accepting edge
//   cancel              pipeline flush; aborts the operation in progress
//   busy                operation in progress
//   done                one-cycle pulse when results are valid
//   quotient, remainder LO/HI values, held until the next done
//   div_by_zero         divisor was zero; held until the next done
module mips_iter_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] r_q;      // partial remainder
    logic [WIDTH-1:0] q_q;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q;      // divisor magnitude
    logic             q_neg;    // negate quotient in FIX
    logic             r_neg;    // negate remainder in FIX

    logic             accept_c;
    logic             divisor_zero_c;
    logic [WIDTH-1:0] dividend_mag_c;
    logic [WIDTH-1:0] divisor_mag_c;
    logic [WIDTH:0]   r_shift_c;
    logic             fits_c;

    // Operand magnitudes and the per-iteration trial subtract.
    // The shifted remainder needs WIDTH+1 bits: for DIVU the divisor may use the MSB.
    always_comb begin
        accept_c       = start && !cancel && (state == IDLE);
        divisor_zero_c = (divisor == '0);
        dividend_mag_c = (is_signed && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
        divisor_mag_c  = (is_signed && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;
        r_shift_c      = {r_q, q_q[WIDTH-1]};
        fits_c         = (r_shift_c >= {1'b0, d_q});
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = divisor_zero_c ? ZERO : RUN;
                end
            end
            RUN: begin
                if (cancel) begin
                    state_nxt = IDLE;
                end else if (count == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            ZERO:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        busy  <= 1'b1;
                        count <= CW'(WIDTH - 1);
                        r_q   <= '0;
                        // A zero divisor keeps the raw dividend for HI.
                        q_q   <= divisor_zero_c ? dividend : dividend_mag_c;
                        d_q   <= divisor_mag_c;
                        q_neg <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg <= is_signed && dividend[WIDTH-1];
                    end
                end
                RUN: begin
                    if (cancel) begin
                        busy <= 1'b0;
                    end else begin
                        r_q   <= fits_c ? WIDTH'(r_shift_c - {1'b0, d_q}) : r_shift_c[WIDTH-1:0];
                        q_q   <= {q_q[WIDTH-2:0], fits_c};
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    if (!cancel) begin
                        quotient    <= q_neg ? WIDTH'(-q_q) : q_q;
                        remainder   <= r_neg ? WIDTH'(-r_q) : r_q;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                ZERO: begin
                    busy <= 1'b0;
                    if (!cancel) begin
                        quotient    <= '1;
                        remainder   <= q_q;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule
